// File: rtl/us_interval_meter_pkg.sv
// rtl/us_interval_meter_pkg.sv - shared state encodings and timing constants
package us_interval_meter_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // 50 MHz system clock: clk cycles per microsecond, shared with the delay counter
  localparam int TICKS_PER_US = 50;

endpackage

// File: rtl/us_interval_meter_tick.sv
// rtl/us_interval_meter_tick.sv - microsecond prescaler producing a one-cycle tick
module us_tick_gen #(
  parameter int TICK_DIV   = 50,
  parameter int PRESC_WIDE = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam logic [PRESC_WIDE-1:0] PRESC_TOP = PRESC_WIDE'(TICK_DIV - 1);

  logic [PRESC_WIDE-1:0] presc;

  // Tick is combinational so the consumer sees it in the cycle the prescaler tops out
  assign tick = en && (presc == PRESC_TOP);

  // Prescaler: clear wins over counting; wraps to zero at the top value
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if (en) begin
      if (presc == PRESC_TOP) presc <= '0;
      else                    presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/us_interval_meter.sv
// rtl/us_interval_meter.sv - measures start-to-stop interval in microseconds
module us_interval_meter
  import us_interval_meter_pkg::*;
#(
  parameter int WIDE       = 32,
  parameter int TICK_DIV   = TICKS_PER_US,
  parameter int PRESC_WIDE = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic [WIDE-1:0] max_count,
  input  logic            ack,
  output logic [WIDE-1:0] elapsed,
  output logic            elapsed_valid,
  output logic            overflow,
  output logic            busy
);

  state_t          state_q, state_d;
  logic [WIDE-1:0] cnt_q, cnt_d;
  logic [WIDE-1:0] limit_q, limit_d;
  logic [WIDE-1:0] elapsed_q, elapsed_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic [WIDE-1:0] cnt_next;
  logic            wrap;
  logic            tick;

  us_tick_gen #(
    .TICK_DIV  (TICK_DIV),
    .PRESC_WIDE(PRESC_WIDE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(start),
    .en   (state_q == ST_RUN),
    .tick (tick)
  );

  assign cnt_next      = cnt_q + {{(WIDE-1){1'b0}}, tick};
  assign wrap          = tick && (&cnt_q);
  assign elapsed       = elapsed_q;
  assign elapsed_valid = valid_q;
  assign overflow      = ovf_q;
  assign busy          = (state_q == ST_RUN);

  // Next-state and result logic; a start in any state restarts and overrides the rest
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    limit_d   = limit_q;
    elapsed_d = elapsed_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        cnt_d = cnt_next;
        if (stop) begin
          state_d   = ST_HOLD;
          elapsed_d = cnt_next;
          valid_d   = 1'b1;
          ovf_d     = 1'b0;
        end else if ((limit_q != '0) && (cnt_next == limit_q)) begin
          state_d   = ST_HOLD;
          elapsed_d = limit_q;
          valid_d   = 1'b1;
          ovf_d     = 1'b1;
        end else if (wrap) begin
          state_d   = ST_HOLD;
          elapsed_d = '1;
          valid_d   = 1'b1;
          ovf_d     = 1'b1;
        end
      end
      ST_HOLD: begin
        if (ack) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      limit_d = max_count;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  // State, counter and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      limit_q   <= '0;
      elapsed_q <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      limit_q   <= limit_d;
      elapsed_q <= elapsed_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_us_interval_meter.sv
// tb/tb_us_interval_meter.sv - directed self-checking bench for us_interval_meter
module tb_us_interval_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, ack = 1'b0;
  logic [31:0] max_count = '0;
  logic [31:0] elapsed;
  logic        elapsed_valid, overflow, busy;

  logic        start2 = 1'b0, stop2 = 1'b0, ack2 = 1'b0;
  logic [3:0]  max_count2 = '0;
  logic [3:0]  elapsed2;
  logic        elapsed_valid2, overflow2, busy2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  us_interval_meter dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .max_count(max_count),
    .ack(ack), .elapsed(elapsed), .elapsed_valid(elapsed_valid),
    .overflow(overflow), .busy(busy)
  );

  us_interval_meter #(.WIDE(4), .TICK_DIV(2), .PRESC_WIDE(2)) dut_small (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2), .max_count(max_count2),
    .ack(ack2), .elapsed(elapsed2), .elapsed_valid(elapsed_valid2),
    .overflow(overflow2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  initial begin
    step(3);
    check("rst_elapsed", elapsed, 0);
    check("rst_valid", elapsed_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_small_valid", elapsed_valid2, 0);
    rst = 1'b1;
    step(2);

    // 1: stop at T0+360 -> 7 us; ack releases result
    max_count = 0;
    pulse_start();
    step(359);
    check("t1_busy", busy, 1);
    check("t1_valid_pre", elapsed_valid, 0);
    stop = 1'b1; step(1); stop = 1'b0;
    check("t1_elapsed", elapsed, 7);
    check("t1_valid", elapsed_valid, 1);
    check("t1_overflow", overflow, 0);
    check("t1_busy_hold", busy, 0);
    stop = 1'b1; step(8); stop = 1'b0;
    check("t1_hold_valid", elapsed_valid, 1);
    check("t1_hold_elapsed", elapsed, 7);
    ack = 1'b1; step(1); ack = 1'b0;
    check("t1_ack_valid", elapsed_valid, 0);
    check("t1_ack_elapsed", elapsed, 7);

    // 2: limit of 3 us ends the measurement at T0+150
    max_count = 3;
    pulse_start();
    max_count = 0;
    step(149);
    check("t2_busy_pre", busy, 1);
    check("t2_valid_pre", elapsed_valid, 0);
    step(1);
    check("t2_elapsed", elapsed, 3);
    check("t2_overflow", overflow, 1);
    check("t2_valid", elapsed_valid, 1);
    check("t2_busy", busy, 0);

    // 6a: start together with ack in HOLD restarts and clears overflow
    start = 1'b1; ack = 1'b1; step(1); start = 1'b0; ack = 1'b0;
    check("t6_valid", elapsed_valid, 0);
    check("t6_busy", busy, 1);
    check("t6_overflow", overflow, 0);
    step(9);
    stop = 1'b1; step(1); stop = 1'b0;
    check("t6_elapsed", elapsed, 0);
    ack = 1'b1; step(1); ack = 1'b0;

    // 3: stop coincident with the third tick is included
    pulse_start();
    step(149);
    stop = 1'b1; step(1); stop = 1'b0;
    check("t3_elapsed", elapsed, 3);
    check("t3_overflow", overflow, 0);
    ack = 1'b1; step(1); ack = 1'b0;

    // 4: restart at T0+260, stop 100 cycles later -> 2 us
    pulse_start();
    step(259);
    pulse_start();
    step(99);
    stop = 1'b1; step(1); stop = 1'b0;
    check("t4_elapsed", elapsed, 2);
    check("t4_valid", elapsed_valid, 1);
    ack = 1'b1; step(1); ack = 1'b0;

    // 5: reset mid-run clears everything; stop without start does nothing
    pulse_start();
    step(209);
    rst = 1'b0; step(1); rst = 1'b1;
    check("t5_elapsed", elapsed, 0);
    check("t5_valid", elapsed_valid, 0);
    check("t5_overflow", overflow, 0);
    check("t5_busy", busy, 0);
    stop = 1'b1; step(1); stop = 1'b0;
    step(2);
    check("t5_stop_valid", elapsed_valid, 0);
    check("t5_stop_busy", busy, 0);

    // 6b: 4-bit counter saturates at 15 on the 16th tick
    pulse_start_small();
    step(31);
    check("t6s_busy_pre", busy2, 1);
    check("t6s_valid_pre", elapsed_valid2, 0);
    step(1);
    check("t6s_elapsed", elapsed2, 15);
    check("t6s_overflow", overflow2, 1);
    check("t6s_valid", elapsed_valid2, 1);
    check("t6s_busy", busy2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic pulse_start_small();
    start2 = 1'b1; step(1); start2 = 1'b0;
  endtask

endmodule
